// File: rtl/debounce_pkg.sv
// debounce_pkg
// Shared constants and helpers for the slide-switch debouncer.
//   DB_TICK_CYCLES_50MHZ_1MS : clock cycles per 1 ms sample tick at 50 MHz
//   DB_STABLE_TICKS          : ticks a new level must persist before acceptance
//   db_cnt_width()           : width of a per-bit stability counter
package debounce_pkg;

  localparam int DB_TICK_CYCLES_50MHZ_1MS = 50000;
  localparam int DB_STABLE_TICKS          = 10;

  // The counter must be able to hold STABLE_TICKS-1; sizing for STABLE_TICKS
  // keeps the width at least 1 even when STABLE_TICKS is 1.
  function automatic int db_cnt_width(input int stable_ticks);
    return $clog2(stable_ticks + 1);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// debounce_bit
// One switch channel: 2-flop synchronizer, stability counter, debounced level
// register and registered rise/fall pulses.
//   clock  : system clock, rising edge
//   reset  : synchronous, active-high
//   tick   : one-cycle sample strobe shared by all channels
//   raw    : asynchronous switch pin
//   db     : debounced level
//   rise   : one-cycle pulse in the first cycle db reads 1
//   fall   : one-cycle pulse in the first cycle db reads 0
//   accept : combinational, high in the cycle before db takes a new value
module debounce_bit
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS = DB_STABLE_TICKS
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall,
  output logic accept
);

  localparam int CW = db_cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic          sync_a;
  logic          s;
  logic [CW-1:0] cnt;

  // The change is taken on the tick that finds the counter already at its
  // last value, so the new level has been seen on STABLE_TICKS ticks in a row.
  assign accept = tick && (s != db) && (cnt == CNT_LAST);

  // Synchronizer, stability counter, level and pulses share one register
  // block so the pulses land in exactly the cycle the new level appears.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_a <= 1'b0;
      s      <= 1'b0;
      cnt    <= '0;
      db     <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_a <= raw;
      s      <= sync_a;
      rise   <= 1'b0;
      fall   <= 1'b0;
      if (s == db) begin
        // A reversion cancels any pending change right away, tick or not.
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CNT_LAST) begin
          db   <= s;
          cnt  <= '0;
          rise <= s;
          fall <= ~s;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/sw_debounce.sv
// sw_debounce
// Debounces and edge-detects the slide switches ahead of the switch PIO.
//   CLOCK_50 : system clock, rising edge
//   reset    : synchronous, active-high
//   sw_raw   : asynchronous switch pins
//   sw_db    : debounced levels (to switch_external_connection_export)
//   sw_rise  : one-cycle pulse per bit on a debounced 0->1
//   sw_fall  : one-cycle pulse per bit on a debounced 1->0
//   changed  : one-cycle pulse, OR of all rise/fall bits
module sw_debounce
  import debounce_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int TICK_CYCLES  = DB_TICK_CYCLES_50MHZ_1MS,
  parameter int STABLE_TICKS = DB_STABLE_TICKS
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             changed
);

  localparam int PW = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES - 1);

  logic [PW-1:0]    pre;
  logic             tick;
  logic [WIDTH-1:0] accept;

  assign tick = (pre == PRE_LAST);

  // Free-running prescaler; tick marks its terminal count.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_bit (
      .clock (CLOCK_50),
      .reset (reset),
      .tick  (tick),
      .raw   (sw_raw[i]),
      .db    (sw_db[i]),
      .rise  (sw_rise[i]),
      .fall  (sw_fall[i]),
      .accept(accept[i])
    );
  end

  // Registered from the per-bit accept strobes so it lines up with the
  // registered rise/fall pulses.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      changed <= 1'b0;
    end else begin
      changed <= |accept;
    end
  end

endmodule
